// File: rtl/conv_window_reader.sv
// Sliding KxK window address generator and pixel streamer.
// Reads an image memory and emits window pixels with first/last tags.
module conv_window_reader #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_first,
  output logic          pix_last,
  output logic          frame_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] KM1  = AW'(K - 1);
  localparam logic [AW-1:0] CMAX = AW'(IMG_W - K);
  localparam logic [AW-1:0] RMAX = AW'(IMG_H - K);
  localparam logic [AW-1:0] WA   = AW'(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] r, c, kr, kc;
  logic          inflight;
  logic [2:0]    tag;
  logic [DW+2:0] ent0, ent1, head;
  logic          wptr, rptr;
  logic [1:0]    cnt, credit;
  logic          push, pop, run;
  logic          wrap_kc, wrap_kr, wrap_c, wrap_r, fin;

  assign run     = (state == RUN);
  assign wrap_kc = (kc == KM1);
  assign wrap_kr = (kr == KM1);
  assign wrap_c  = (c == CMAX);
  assign wrap_r  = (r == RMAX);

  assign push      = inflight;
  assign pix_valid = (cnt != 2'd0);
  assign pop       = pix_valid && pix_ready;

  // A slot freed by this cycle's pop counts as free, so a read can
  // issue every cycle while the consumer keeps up.
  assign credit = cnt + {1'b0, inflight} - {1'b0, pop};
  assign mem_en = run && (credit < 2'd2);
  assign fin    = mem_en && wrap_kc && wrap_kr && wrap_c && wrap_r;

  assign mem_addr = (r + kr) * WA + c + kc;

  assign head = rptr ? ent1 : ent0;
  assign {pix_data, pix_first, pix_last, frame_last} = head;

  assign busy = (state != IDLE) || done;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: run until final read issued, drain until final pixel leaves.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (fin) state_nx = DRAIN;
      DRAIN:   if (pop && head[0]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window counters: kc fastest, then kr, then c, then r; step per read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r  <= '0;
      c  <= '0;
      kr <= '0;
      kc <= '0;
    end else if (mem_en) begin
      if (!wrap_kc) begin
        kc <= kc + ONE;
      end else begin
        kc <= '0;
        if (!wrap_kr) begin
          kr <= kr + ONE;
        end else begin
          kr <= '0;
          if (!wrap_c) begin
            c <= c + ONE;
          end else begin
            c <= '0;
            if (!wrap_r) r <= r + ONE;
            else         r <= '0;
          end
        end
      end
    end
  end

  // Tag pipeline: flags ride alongside the read for its one-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= mem_en;
      if (mem_en) begin
        tag <= {(kr == '0) && (kc == '0),
                wrap_kr && wrap_kc,
                wrap_kr && wrap_kc && wrap_c && wrap_r};
      end
    end
  end

  // Two-entry output FIFO holding returned data with its flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        if (wptr) ent1 <= {mem_rdata, tag};
        else      ent0 <= {mem_rdata, tag};
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Done pulses the cycle after the final pixel is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == DRAIN) && pop && head[0];
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader at default parameters.
// Memory model returns a scrambled address byte one cycle after mem_en.
module tb_conv_window_reader;

  localparam int NPIX = 6084;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] mem_addr;
  logic       mem_en;
  logic [7:0] mem_rdata = 8'd0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_first;
  logic       pix_last;
  logic       frame_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int issue_cnt, xfer_cnt, last_cnt;
  int first_cyc, fl_cyc, done_cyc;
  bit done_seen, hold_v, mon_on, busy_at_done;
  logic [10:0] hold_val;
  logic [9:0]  addr_log [NPIX];

  int first18 [18] = '{0, 1, 2, 28, 29, 30, 56, 57, 58,
                       1, 2, 3, 29, 30, 31, 57, 58, 59};
  int last9 [9] = '{725, 726, 727, 753, 754, 755, 781, 782, 783};

  conv_window_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_first (pix_first),
    .pix_last  (pix_last),
    .frame_last(frame_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [9:0] a);
    logic [7:0] hi;
    hi = {6'd0, a[9:8]};
    return a[7:0] ^ (hi * 8'h55);
  endfunction

  function automatic int exp_addr(input int p);
    int w, k, r, c;
    w = p / 9;
    k = p % 9;
    r = w / 26;
    c = w % 26;
    return (r + k / 3) * 28 + c + k % 3;
  endfunction

  function automatic logic [31:0] outs();
    return {7'd0, mem_addr, mem_en, pix_valid, pix_data,
            pix_first, pix_last, frame_last, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= memf(mem_addr);
  end

  // Monitor: issued addresses, transferred pixels, hold stability.
  always @(negedge clk) begin
    logic [10:0] cur;
    int k;
    cyc++;
    cur = {pix_data, pix_first, pix_last, frame_last};
    if (mon_on && !reset) begin
      if (hold_v) check("hold", {21'd0, pix_valid, cur}, {21'd0, 1'b1, hold_val});
      hold_v = pix_valid && !pix_ready;
      hold_val = cur;
      if (mem_en) begin
        if (issue_cnt < NPIX) begin
          addr_log[issue_cnt] = mem_addr;
          check("addr", {22'd0, mem_addr}, exp_addr(issue_cnt));
        end else begin
          check("extra_issue", 1, 0);
        end
        issue_cnt++;
      end
      if (pix_valid && pix_ready) begin
        if (xfer_cnt < NPIX) begin
          k = xfer_cnt % 9;
          check("pixel", {21'd0, cur},
                {21'd0, memf(10'(exp_addr(xfer_cnt))), k == 0, k == 8,
                 xfer_cnt == NPIX - 1});
        end else begin
          check("extra_xfer", 1, 0);
        end
        if (xfer_cnt == 0) first_cyc = cyc;
        if (pix_last) last_cnt++;
        if (frame_last) fl_cyc = cyc;
        xfer_cnt++;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic mon_clear();
    issue_cnt = 0;
    xfer_cnt = 0;
    last_cnt = 0;
    first_cyc = 0;
    fl_cyc = 0;
    done_cyc = 0;
    done_seen = 1'b0;
    hold_v = 1'b0;
    busy_at_done = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("first_issue", {mem_en, mem_addr, pix_valid, busy},
          {1'b1, 10'd0, 1'b0, 1'b1});
    @(negedge clk);
    check("lat1", {31'd0, pix_valid}, 0);
    @(negedge clk);
    check("lat2", {31'd0, pix_valid}, 1);
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      if (done_seen) break;
    end
    check("done_seen", {31'd0, done_seen}, 1);
    pix_ready = 1'b1;
    @(negedge clk);
    check("busy_after", {30'd0, busy, done}, 0);
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt >= n) break;
    end
    check("reach_xfers", {31'd0, xfer_cnt >= n}, 1);
  endtask

  task automatic end_checks();
    check("xfer_count", xfer_cnt, NPIX);
    check("issue_count", issue_cnt, NPIX);
    check("last_count", last_cnt, 676);
    check("done_delay", done_cyc - fl_cyc, 1);
    check("busy_at_done", {31'd0, busy_at_done}, 1);
  endtask

  initial begin
    int x0;
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    mon_on = 1'b0;
    mon_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 0);

    // Frame 1: full rate, with a stray start during RUN.
    mon_clear();
    mon_on = 1'b1;
    pix_ready = 1'b1;
    pulse_start();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20000, 1'b0);
    end_checks();
    check("thruput", fl_cyc - first_cyc, NPIX - 1);
    for (int i = 0; i < 18; i++)
      check("head_addr", {22'd0, addr_log[i]}, first18[i]);
    for (int i = 0; i < 9; i++)
      check("tail_addr", {22'd0, addr_log[NPIX - 9 + i]}, last9[i]);

    // Frame 2: 5-cycle stall mid-window, then random ready.
    mon_clear();
    pulse_start();
    wait_xfers(40);
    pix_ready = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        check("stall_en", {31'd0, mem_en}, 0);
        check("stall_full", issue_cnt - xfer_cnt, 2);
      end
    end
    check("stall_xfers", xfer_cnt, x0);
    wait_done(40000, 1'b1);
    end_checks();

    // Frame 3: reset at pixel 1000, then a clean restart.
    mon_clear();
    pix_ready = 1'b1;
    pulse_start();
    wait_xfers(1000);
    reset = 1'b1;
    #2;
    check("abort_outs", outs(), 0);
    mon_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset", outs(), 0);
    mon_clear();
    mon_on = 1'b1;
    pulse_start();
    wait_done(20000, 1'b0);
    end_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_reader.md
CONV_WINDOW_READER -- requirements
Module: conv_window_reader

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Parameter K, default 3, square convolution window edge.
REQ-004 Parameter DW, default 8, pixel data width.
REQ-005 Parameter AW, default 10, image memory address width.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  one-cycle pulse; begins one frame traversal when idle.
REQ-009 mem_addr  output  AW  image memory read address.
REQ-010 mem_en  output  1  read strobe; mem_rdata valid exactly 1 cycle later.
REQ-011 mem_rdata  input  DW  image memory read data.
REQ-012 pix_data  output  DW  window pixel to convolution stage.
REQ-013 pix_valid  output  1  pix_data/flags valid.
REQ-014 pix_ready  input  1  downstream accepts; transfer when pix_valid && pix_ready.
REQ-015 pix_first  output  1  pixel is first (kr=0,kc=0) of its window.
REQ-016 pix_last  output  1  pixel is last (kr=K-1,kc=K-1) of its window.
REQ-017 frame_last  output  1  pixel is last of the final window.
REQ-018 busy  output  1  high from accepted start until done.
REQ-019 done  output  1  one-cycle pulse at frame completion.

Function
REQ-020 Output positions (r,c) SHALL cover r,c in 0..IMG_H-K / 0..IMG_W-K, row-major (c fastest); 26x26=676 windows at defaults.
REQ-021 Within a window, pixels SHALL be emitted kr-major, kc-minor; address = (r+kr)*IMG_W + (c+kc), computed in AW bits, never exceeding IMG_W*IMG_H-1 (783).
REQ-022 Total pixels per frame SHALL be (IMG_H-K+1)*(IMG_W-K+1)*K*K (6084 at defaults); no pixel duplicated or skipped.
REQ-023 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN after final address issued; DRAIN->IDLE when final pixel transferred, with done pulsed that cycle+1.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Output buffer: 2-entry FIFO holding {data, first, last, frame_last}; flags travel with the read via a 1-cycle tag pipeline.
REQ-026 mem_en SHALL assert only when (FIFO occupancy + reads in flight) < 2; address counters advance only on mem_en.
REQ-027 pix_valid SHALL equal FIFO not-empty; pix_data/flags held stable while pix_valid && !pix_ready.
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged, data order preserved.
REQ-029 With pix_ready held high, throughput SHALL be one pixel per cycle; first pix_valid 2 cycles after start (1 cycle to issue, 1 memory latency).
REQ-030 busy SHALL be high from cycle after start through the done cycle inclusive.

Reset
REQ-031 On reset: FSM=IDLE, counters r,c,kr,kc=0, FIFO empty, in-flight tag cleared; mem_addr=0, mem_en=0, pix_valid=0, pix_first/last/frame_last=0, busy=0, done=0.
REQ-032 Reset mid-frame SHALL abort immediately; returned read data after reset SHALL be discarded; next start begins at window (0,0).

Verification
REQ-033 pix_ready=1, start -> first 9 addresses 0,1,2,28,29,30,56,57,58 with pix_first on 1st, pix_last on 9th; second window 1,2,3,29,30,31,57,58,59.
REQ-034 pix_ready=1 full frame -> exactly 6084 transfers; final window 725,726,727,753,754,755,781,782,783; frame_last on last; done one cycle later; busy low after.
REQ-035 pix_ready low 5 cycles mid-window -> mem_en stops with FIFO full, pix_data stable, no loss/duplicate on release.
REQ-036 Random pix_ready (50%) full frame -> output sequence equals golden model, 676 pix_last pulses.
REQ-037 start pulsed during RUN -> ignored, sequence unaffected; reset at pixel 1000 -> all outputs zero, new start restarts at address 0.
